// File: rtl/fir_tap_scheduler.sv
// rtl/fir_tap_scheduler.sv - time-multiplexed FIR controller with shared MAC, delay line and coefficient bank
module fir_tap_scheduler #(
  parameter int N     = 4,
  parameter int AW    = 2,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [7:0]       x_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] y_out,
  input  logic                    coef_we,
  input  logic [AW-1:0]           coef_addr,
  input  logic signed [7:0]       coef_data,
  output logic                    busy,
  output logic                    coef_err
);

  // Tap counter only needs to span 0..N-1.
  localparam int TW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [TW-1:0]           tap_q, tap_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] y_q, y_d;
  logic                    out_valid_q, out_valid_d;
  logic                    coef_err_q, coef_err_d;

  logic signed [7:0]       x_q [N];
  logic signed [7:0]       h_q [N];

  logic                    accept;
  logic                    last_tap;
  logic                    coef_ok;
  logic [TW-1:0]           waddr;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] mac_sum;

  assign accept   = (state_q == S_IDLE) && in_valid;
  assign last_tap = (tap_q == TW'(N - 1));
  // Writes land only while idle and only to taps that exist.
  assign coef_ok  = (state_q == S_IDLE) && (32'(coef_addr) < 32'(N));
  assign waddr    = TW'(coef_addr);

  // Single shared multiplier; the signed width cast sign-extends or truncates to the accumulator.
  assign prod     = x_q[tap_q] * h_q[tap_q];
  assign prod_ext = ACC_W'(prod);
  assign mac_sum  = acc_q + prod_ext;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign y_out     = y_q;
  assign coef_err  = coef_err_q;

  // Next-state logic for the IDLE -> MAC -> OUT sequence and the datapath registers.
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    coef_err_d  = coef_we && !coef_ok;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = '0;
          tap_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = mac_sum;
        tap_d = tap_q + 1'b1;
        if (last_tap) begin
          tap_d       = '0;
          y_d         = mac_sum;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control and accumulator registers; reset abandons any in-flight sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      coef_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      coef_err_q  <= coef_err_d;
    end
  end

  // Delay line shifts on accept; coefficient bank takes idle writes (visible to a same-edge sample's MAC).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        x_q[i] <= '0;
        h_q[i] <= 8'(i + 1);
      end
    end else begin
      if (accept) begin
        x_q[0] <= x_in;
        for (int i = 1; i < N; i++) begin
          x_q[i] <= x_q[i-1];
        end
      end
      if (coef_we && coef_ok) begin
        h_q[waddr] <= coef_data;
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// tb/tb_fir_tap_scheduler.sv - scoreboard bench for fir_tap_scheduler
module tb_fir_tap_scheduler;

  localparam int N     = 4;
  localparam int AW    = 3;
  localparam int ACC_W = 16;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [7:0]       x_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] y_out;
  logic                    coef_we;
  logic [AW-1:0]           coef_addr;
  logic signed [7:0]       coef_data;
  logic                    busy;
  logic                    coef_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic signed [15:0] exp_q[$];

  fir_tap_scheduler #(.N(N), .AW(AW), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy), .coef_err(coef_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL y_out_unexpected: got %0d expected no result", y_out);
      end else begin
        check("y_out", int'(y_out), int'(exp_q.pop_front()));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic signed [7:0] x, input logic signed [15:0] e,
                      input bit push, output int t);
    int n = 0;
    in_valid = 1'b1;
    x_in     = x;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    if (push) exp_q.push_back(e);
    @(negedge clk);
    t        = cyc;
    in_valid = 1'b0;
    x_in     = '0;
    check("busy_after_accept", busy, 1);
    check("in_ready_after_accept", in_ready, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && exp_q.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(in_ready && exp_q.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: pending results got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_y_out", int'(y_out), 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_coef_err", coef_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic impulse();
    int t;
    send(8'sd1, 16'sd1, 1'b1, t);
    send(8'sd0, 16'sd2, 1'b1, t);
    send(8'sd0, 16'sd3, 1'b1, t);
    send(8'sd0, 16'sd4, 1'b1, t);
    send(8'sd0, 16'sd0, 1'b1, t);
    wait_idle();
  endtask

  initial begin
    int t;
    int ta[4];
    int n;
    logic signed [15:0] step_exp[4];
    logic signed [15:0] wrap_exp[4];
    step_exp = '{16'sd10, 16'sd30, 16'sd60, 16'sd100};
    wrap_exp = '{16'sd16129, 16'sd32258, -16'sd17149, -16'sd1020};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    x_in      = '0;
    out_ready = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    @(negedge clk);
    apply_reset();

    // Impulse with default coefficients 1,2,3,4
    impulse();

    // Step response and accept spacing of N+2 cycles
    for (int i = 0; i < 4; i++) send(8'sd10, step_exp[i], 1'b1, ta[i]);
    for (int i = 0; i < 3; i++) check("accept_spacing", ta[i+1] - ta[i], N + 2);
    wait_idle();

    // Overflow wrap with all coefficients at 127
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      coef_we   = 1'b1;
      coef_addr = AW'(i);
      coef_data = 8'sd127;
      @(negedge clk);
      check("coef_err_valid_write", coef_err, 0);
    end
    coef_we = 1'b0;
    for (int i = 0; i < 4; i++) send(8'sd127, wrap_exp[i], 1'b1, t);
    wait_idle();

    // Backpressure: result held, pending sample waits
    out_ready = 1'b0;
    send(8'sd0, -16'sd17149, 1'b1, t);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", out_valid, 1);
    in_valid = 1'b1;
    x_in     = 8'sd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_y_hold", int'(y_out), -17149);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    exp_q.push_back(-16'sd32643);
    @(posedge clk);
    @(negedge clk);
    check("bp_pending_accepted", busy, 1);
    in_valid = 1'b0;
    x_in     = '0;
    wait_idle();

    // Rejected writes during MAC, back to back
    apply_reset();
    send(8'sd1, 16'sd1, 1'b1, t);
    wait_idle();
    send(8'sd2, 16'sd4, 1'b1, t);
    coef_we   = 1'b1;
    coef_addr = 3'd1;
    coef_data = -8'sd5;
    @(negedge clk);
    check("coef_err_busy_1", coef_err, 1);
    @(negedge clk);
    check("coef_err_busy_2", coef_err, 1);
    coef_we = 1'b0;
    @(negedge clk);
    check("coef_err_busy_clear", coef_err, 0);
    wait_idle();

    // Out-of-range address in IDLE
    coef_we   = 1'b1;
    coef_addr = 3'd4;
    coef_data = 8'sd99;
    @(negedge clk);
    check("coef_err_range", coef_err, 1);
    coef_we = 1'b0;
    @(negedge clk);
    check("coef_err_range_clear", coef_err, 0);
    send(8'sd3, 16'sd10, 1'b1, t);
    wait_idle();

    // Coefficient write coincident with sample accept
    apply_reset();
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = -8'sd3;
    send(8'sd2, -16'sd6, 1'b1, t);
    coef_we = 1'b0;
    check("coef_err_coincident", coef_err, 0);
    wait_idle();

    // Reset during the second MAC cycle discards the sample
    send(8'sd7, 16'sd0, 1'b0, t);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_y_out", int'(y_out), 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    impulse();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
